pipeline_sequencer: RTL and testbench

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

---
 rtl/pipeline_sequencer_if.sv | 34 +++
 rtl/pipeline_sequencer.sv | 117 +++++++++++
 tb/tb_pipeline_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_sequencer_if.sv
// Hazard/stall control bundle between the pipeline datapath and the sequencer.
interface pipeline_sequencer_if;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rt;
   logic        ex_mem_read;
   logic [4:0]  ex_rt;
   logic        ex_branch_taken;
   logic        id_jump;
   logic        mem_req;
   logic        mem_ready;
   logic        pc_write;
   logic        if_id_write;
   logic        if_id_flush;
   logic        control_mux;
   logic        pipe_hold;
   logic        mem_error;
   logic [15:0] stall_cycles;
   logic [15:0] flush_count;

   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken,
             id_jump, mem_req, mem_ready,
      output pc_write, if_id_write, if_id_flush, control_mux, pipe_hold,
             mem_error, stall_cycles, flush_count
   );

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken,
             id_jump, mem_req, mem_ready,
      input  pc_write, if_id_write, if_id_flush, control_mux, pipe_hold,
             mem_error, stall_cycles, flush_count
   );
endinterface

// File: rtl/pipeline_sequencer.sv
// Five-stage pipeline hazard sequencer: memory-wait hold with timeout, branch/jump
// flushes, load-use bubbles, plus saturating stall/flush statistics.
module pipeline_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   pipeline_sequencer_if.slave  bus
);
   localparam int unsigned WAIT_W = 8;
   localparam int unsigned CNT_W  = 16;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

   state_t              r_state, w_state_nxt;
   logic [WAIT_W-1:0]   r_wait_cnt, w_wait_cnt_nxt;
   logic [CNT_W-1:0]    r_stall_cycles, r_flush_count;
   logic                r_mem_error;
   logic                w_mem_stall, w_load_use;
   logic                w_pc_write, w_if_id_write, w_if_id_flush, w_control_mux, w_pipe_hold;

   assign w_mem_stall = bus.mem_req & ~bus.mem_ready;
   assign w_load_use  = bus.ex_mem_read & (bus.ex_rt != 5'd0) &
                        ((bus.ex_rt == bus.id_rs) | (bus.id_uses_rt & (bus.ex_rt == bus.id_rt)));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= RUN;
         r_wait_cnt  <= '0;
         r_mem_error <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_wait_cnt  <= w_wait_cnt_nxt;
         r_mem_error <= (w_state_nxt == ERR);
      end
   end

   // Mealy next-state and control; reset forces the frozen-pipeline pattern.
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_pc_write     = 1'b1;
      w_if_id_write  = 1'b1;
      w_if_id_flush  = 1'b0;
      w_control_mux  = 1'b1;
      w_pipe_hold    = 1'b0;
      case (r_state)
         RUN, MEM_WAIT: begin
            if (w_mem_stall) begin
               w_pc_write    = 1'b0;
               w_if_id_write = 1'b0;
               w_pipe_hold   = 1'b1;
               if (r_wait_cnt == WAIT_LAST) begin
                  w_state_nxt = ERR;
               end else begin
                  w_state_nxt    = MEM_WAIT;
                  w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
               end
            end else begin
               w_state_nxt    = RUN;
               w_wait_cnt_nxt = '0;
               if (bus.ex_branch_taken) begin
                  w_if_id_flush = 1'b1;
                  w_control_mux = 1'b0;
               end else if (w_load_use) begin
                  w_pc_write    = 1'b0;
                  w_if_id_write = 1'b0;
                  w_control_mux = 1'b0;
               end else if (bus.id_jump) begin
                  w_if_id_flush = 1'b1;
               end
            end
         end
         ERR: begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_pipe_hold   = 1'b1;
            w_control_mux = 1'b0;
         end
         default: begin
            w_state_nxt    = RUN;
            w_wait_cnt_nxt = '0;
         end
      endcase
      if (reset) begin
         w_pc_write    = 1'b0;
         w_if_id_write = 1'b0;
         w_if_id_flush = 1'b0;
         w_control_mux = 1'b0;
         w_pipe_hold   = 1'b1;
      end
   end

   // Saturating statistics counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         if (!w_pc_write && (r_stall_cycles != CNT_MAX))
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         if (w_if_id_flush && (r_flush_count != CNT_MAX))
            r_flush_count <= r_flush_count + CNT_W'(1);
      end
   end

   assign bus.pc_write     = w_pc_write;
   assign bus.if_id_write  = w_if_id_write;
   assign bus.if_id_flush  = w_if_id_flush;
   assign bus.control_mux  = w_control_mux;
   assign bus.pipe_hold    = w_pipe_hold;
   assign bus.mem_error    = r_mem_error & ~reset;
   assign bus.stall_cycles = r_stall_cycles;
   assign bus.flush_count  = r_flush_count;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed self-checking bench for pipeline_sequencer (MEM_TIMEOUT = 4).
module tb_pipeline_sequencer;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   pipeline_sequencer_if sb ();

   pipeline_sequencer #(.MEM_TIMEOUT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_ctl(input string tag, input logic pc, input logic ifw,
                            input logic fl, input logic cm, input logic ph);
      check_eq({tag, ".pc_write"},    32'(sb.pc_write),    32'(pc));
      check_eq({tag, ".if_id_write"}, 32'(sb.if_id_write), 32'(ifw));
      check_eq({tag, ".if_id_flush"}, 32'(sb.if_id_flush), 32'(fl));
      check_eq({tag, ".control_mux"}, 32'(sb.control_mux), 32'(cm));
      check_eq({tag, ".pipe_hold"},   32'(sb.pipe_hold),   32'(ph));
   endtask

   task automatic idle();
      sb.id_rs = 5'd0; sb.id_rt = 5'd0; sb.id_uses_rt = 1'b0;
      sb.ex_mem_read = 1'b0; sb.ex_rt = 5'd0; sb.ex_branch_taken = 1'b0;
      sb.id_jump = 1'b0; sb.mem_req = 1'b0; sb.mem_ready = 1'b0;
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_load_use();
      sb.ex_mem_read = 1'b1; sb.ex_rt = 5'd8; sb.id_rs = 5'd8;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      idle();
      repeat (2) @(negedge clk);
      check_ctl("reset", 0, 0, 0, 0, 1);
      check_eq("reset.mem_error", 32'(sb.mem_error), 0);
      check_eq("reset.stall", 32'(sb.stall_cycles), 0);
      check_eq("reset.flush", 32'(sb.flush_count), 0);

      next_cyc(); reset = 1'b0;
      @(negedge clk); check_ctl("run_idle", 1, 1, 0, 1, 0);

      // load-use on rs
      next_cyc(); set_load_use();
      @(negedge clk); check_ctl("lu_rs", 0, 0, 0, 0, 0);
      next_cyc(); idle();
      @(negedge clk); check_ctl("after_lu", 1, 1, 0, 1, 0);
      check_eq("lu_rs.stall", 32'(sb.stall_cycles), 1);

      // r0 destination never stalls
      next_cyc(); sb.ex_mem_read = 1'b1; sb.id_uses_rt = 1'b1;
      @(negedge clk); check_ctl("lu_r0", 1, 1, 0, 1, 0);

      // rt match only counts when rt is read
      next_cyc(); idle(); sb.ex_mem_read = 1'b1; sb.ex_rt = 5'd5; sb.id_rs = 5'd3; sb.id_rt = 5'd5;
      @(negedge clk); check_ctl("lu_rt_unused", 1, 1, 0, 1, 0);
      check_eq("lu_r0.stall", 32'(sb.stall_cycles), 1);
      next_cyc(); sb.id_uses_rt = 1'b1;
      @(negedge clk); check_ctl("lu_rt", 0, 0, 0, 0, 0);
      next_cyc(); idle();
      @(negedge clk); check_eq("lu_rt.stall", 32'(sb.stall_cycles), 2);

      // branch beats load-use
      next_cyc(); set_load_use(); sb.ex_branch_taken = 1'b1;
      @(negedge clk); check_ctl("br_lu", 1, 1, 1, 0, 0);
      next_cyc(); idle();
      @(negedge clk); check_eq("br_lu.flush", 32'(sb.flush_count), 1);
      check_eq("br_lu.stall", 32'(sb.stall_cycles), 2);

      // jump alone, then load-use beats jump
      next_cyc(); sb.id_jump = 1'b1;
      @(negedge clk); check_ctl("jump", 1, 1, 1, 1, 0);
      next_cyc(); set_load_use();
      @(negedge clk); check_ctl("jump_lu", 0, 0, 0, 0, 0);
      next_cyc(); idle();
      @(negedge clk); check_eq("jump.flush", 32'(sb.flush_count), 2);
      check_eq("jump.stall", 32'(sb.stall_cycles), 3);

      // three wait cycles with branch pending, then release into the flush
      for (int i = 0; i < 3; i++) begin
         next_cyc(); sb.mem_req = 1'b1; sb.mem_ready = 1'b0; sb.ex_branch_taken = 1'b1;
         @(negedge clk); check_ctl($sformatf("wait%0d", i), 0, 0, 0, 1, 1);
      end
      next_cyc(); sb.mem_ready = 1'b1;
      @(negedge clk); check_ctl("wait_rel", 1, 1, 1, 0, 0);
      next_cyc(); idle();
      @(negedge clk); check_ctl("wait_run", 1, 1, 0, 1, 0);
      check_eq("wait.stall", 32'(sb.stall_cycles), 6);
      check_eq("wait.flush", 32'(sb.flush_count), 3);
      check_eq("wait.mem_error", 32'(sb.mem_error), 0);

      // wait counter must restart after each release
      for (int i = 0; i < 3; i++) begin
         next_cyc(); sb.mem_req = 1'b1; sb.mem_ready = 1'b0;
         @(negedge clk); check_ctl($sformatf("rewait%0d", i), 0, 0, 0, 1, 1);
      end
      next_cyc(); sb.mem_ready = 1'b1;
      @(negedge clk); check_ctl("rewait_rel", 1, 1, 0, 1, 0);
      check_eq("rewait.mem_error", 32'(sb.mem_error), 0);
      next_cyc(); idle();
      @(negedge clk); check_eq("rewait.stall", 32'(sb.stall_cycles), 9);

      // timeout: four stall cycles, then ERR
      for (int i = 1; i <= 4; i++) begin
         next_cyc(); sb.mem_req = 1'b1; sb.mem_ready = 1'b0;
         @(negedge clk); check_ctl($sformatf("to%0d", i), 0, 0, 0, 1, 1);
         check_eq($sformatf("to%0d.mem_error", i), 32'(sb.mem_error), 0);
      end
      next_cyc();
      @(negedge clk); check_ctl("err", 0, 0, 0, 0, 1);
      check_eq("err.mem_error", 32'(sb.mem_error), 1);
      next_cyc(); sb.mem_ready = 1'b1; sb.ex_branch_taken = 1'b1;
      @(negedge clk); check_ctl("err_ready", 0, 0, 0, 0, 1);
      check_eq("err_ready.mem_error", 32'(sb.mem_error), 1);
      next_cyc(); idle();
      @(negedge clk); check_ctl("err_idle", 0, 0, 0, 0, 1);
      check_eq("err.stall", 32'(sb.stall_cycles), 15);
      next_cyc(); reset = 1'b1;
      @(negedge clk); check_ctl("err_rst", 0, 0, 0, 0, 1);
      check_eq("err_rst.mem_error", 32'(sb.mem_error), 0);
      next_cyc(); reset = 1'b0;
      @(negedge clk); check_ctl("post_err", 1, 1, 0, 1, 0);
      check_eq("post_err.mem_error", 32'(sb.mem_error), 0);
      check_eq("post_err.stall", 32'(sb.stall_cycles), 0);
      check_eq("post_err.flush", 32'(sb.flush_count), 0);

      // reset in MEM_WAIT discards the wait count
      for (int i = 0; i < 2; i++) begin
         next_cyc(); sb.mem_req = 1'b1; sb.mem_ready = 1'b0;
      end
      next_cyc(); reset = 1'b1;
      @(negedge clk); check_ctl("mw_rst", 0, 0, 0, 0, 1);
      next_cyc(); reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); check_ctl($sformatf("mw_post%0d", i), 0, 0, 0, 1, 1);
         next_cyc();
      end
      sb.mem_ready = 1'b1;
      @(negedge clk); check_ctl("mw_rel", 1, 1, 0, 1, 0);
      check_eq("mw_rel.mem_error", 32'(sb.mem_error), 0);
      next_cyc(); idle();
      @(negedge clk); check_eq("mw.stall", 32'(sb.stall_cycles), 3);

      // stall counter saturation
      next_cyc(); set_load_use();
      repeat (65532) @(posedge clk);
      #1; check_eq("sat.stall_max", 32'(sb.stall_cycles), 32'h0000_FFFF);
      @(posedge clk);
      #1; check_eq("sat.stall_hold", 32'(sb.stall_cycles), 32'h0000_FFFF);
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
